// File: rtl/decode_regfile_pkg.sv
// Shared constants for the decode stage: datapath sizes, link register and
// the I-type opcodes whose immediates are zero-extended.
package decode_regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_AW   = 5;
   localparam int LINK_REG = 31;

   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // Logical immediates and sltiu treat imm16 as unsigned.
   function automatic logic is_zero_ext(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) ||
             (op == OP_XORI) || (op == OP_SLTIU);
   endfunction

endpackage

// File: rtl/decode_regfile_reg_file_32x32.sv
// General register file: async-cleared storage, two combinational read ports
// and one write port that never stores into register 0.
module reg_file_32x32
   import decode_regfile_pkg::*;
#(
   parameter int P_DATA_W = DATA_W,
   parameter int P_REG_AW = REG_AW
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic [P_REG_AW-1:0] i_rd_addr_1,
   input  logic [P_REG_AW-1:0] i_rd_addr_2,
   input  logic                i_we,
   input  logic [P_REG_AW-1:0] i_wr_addr,
   input  logic [P_DATA_W-1:0] i_wr_data,
   output logic [P_DATA_W-1:0] o_rd_data_1,
   output logic [P_DATA_W-1:0] o_rd_data_2
);

   localparam int NUM_REGS = 2 ** P_REG_AW;

   logic [P_DATA_W-1:0] r_regs [NUM_REGS];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wr_addr != '0)) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end
   end

   // Reads see the pre-edge contents; no write-through bypass.
   assign o_rd_data_1 = (i_rd_addr_1 == '0) ? '0 : r_regs[i_rd_addr_1];
   assign o_rd_data_2 = (i_rd_addr_2 == '0) ? '0 : r_regs[i_rd_addr_2];

endmodule

// File: rtl/decode_regfile.sv
// Decode stage: register-file operands, immediate extension and the
// write-back address/data selection for ALU, load and jal-link results.
module decode_regfile
   import decode_regfile_pkg::*;
#(
   parameter int P_DATA_W   = DATA_W,
   parameter int P_REG_AW   = REG_AW,
   parameter int P_LINK_REG = LINK_REG
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic [31:0]         Instruction,
   input  logic [P_DATA_W-1:0] PC_plus_4,
   input  logic [P_DATA_W-1:0] ALU_Result,
   input  logic [P_DATA_W-1:0] mem_data,
   input  logic                RegWrite,
   input  logic                RegDst,
   input  logic                MemtoReg,
   input  logic                Jal,
   output logic [P_DATA_W-1:0] Read_data_1,
   output logic [P_DATA_W-1:0] Read_data_2,
   output logic [P_DATA_W-1:0] Sign_extend
);

   localparam logic [P_REG_AW-1:0] LINK_ADDR = P_REG_AW'(P_LINK_REG);

   logic [5:0]          w_opcode;
   logic [P_REG_AW-1:0] w_rs;
   logic [P_REG_AW-1:0] w_rt;
   logic [P_REG_AW-1:0] w_rd;
   logic [15:0]         w_imm16;
   logic                w_ext_bit;
   logic [P_REG_AW-1:0] w_wr_addr;
   logic [P_DATA_W-1:0] w_wr_data;
   logic                w_we;

   assign w_opcode = Instruction[31:26];
   assign w_rs     = Instruction[21 +: P_REG_AW];
   assign w_rt     = Instruction[16 +: P_REG_AW];
   assign w_rd     = Instruction[11 +: P_REG_AW];
   assign w_imm16  = Instruction[15:0];

   // Jal overrides both the destination and the data source.
   assign w_wr_addr = Jal ? LINK_ADDR : (RegDst ? w_rd : w_rt);
   assign w_wr_data = Jal ? PC_plus_4 : (MemtoReg ? mem_data : ALU_Result);
   assign w_we      = RegWrite | Jal;

   assign w_ext_bit   = is_zero_ext(w_opcode) ? 1'b0 : w_imm16[15];
   assign Sign_extend = {{(P_DATA_W-16){w_ext_bit}}, w_imm16};

   reg_file_32x32 #(
      .P_DATA_W (P_DATA_W),
      .P_REG_AW (P_REG_AW)
   ) u_reg_file (
      .clock       (clock),
      .rst_n       (rst_n),
      .i_rd_addr_1 (w_rs),
      .i_rd_addr_2 (w_rt),
      .i_we        (w_we),
      .i_wr_addr   (w_wr_addr),
      .i_wr_data   (w_wr_data),
      .o_rd_data_1 (Read_data_1),
      .o_rd_data_2 (Read_data_2)
   );

   a_strobes_known: assert property (@(posedge clock) disable iff (!rst_n)
      !$isunknown({RegWrite, Jal}))
      else $error("X on RegWrite/Jal");

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: write-back paths, r0, reset and the
// immediate extender, each checked against hand-computed values.
module tb_decode_regfile;

   logic        clock;
   logic        rst_n;
   logic [31:0] Instruction;
   logic [31:0] PC_plus_4;
   logic [31:0] ALU_Result;
   logic [31:0] mem_data;
   logic        RegWrite;
   logic        RegDst;
   logic        MemtoReg;
   logic        Jal;
   logic [31:0] Read_data_1;
   logic [31:0] Read_data_2;
   logic [31:0] Sign_extend;

   int n_checks = 0;
   int n_pass   = 0;

   decode_regfile dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .Instruction (Instruction),
      .PC_plus_4   (PC_plus_4),
      .ALU_Result  (ALU_Result),
      .mem_data    (mem_data),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .Jal         (Jal),
      .Read_data_1 (Read_data_1),
      .Read_data_2 (Read_data_2),
      .Sign_extend (Sign_extend)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("ok   %-12s got %08h", tag, obs);
      end else begin
         $display("FAIL %-12s got %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] r_instr(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 5'd0, 6'd0};
   endfunction

   function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [15:0] imm);
      return {op, 5'd0, 5'd0, imm};
   endfunction

   // Drive one write-back cycle from a falling edge through the next rising edge.
   task automatic wb_cycle(input logic [31:0] instr, input logic we, input logic dst,
                           input logic m2r, input logic jal, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [31:0] pc);
      @(negedge clock);
      Instruction = instr; RegWrite = we; RegDst = dst; MemtoReg = m2r; Jal = jal;
      ALU_Result = alu; mem_data = mem; PC_plus_4 = pc;
      @(posedge clock);
      #1;
      RegWrite = 1'b0; RegDst = 1'b0; MemtoReg = 1'b0; Jal = 1'b0;
   endtask

   task automatic wr_rd(input logic [4:0] rd, input logic [31:0] val);
      wb_cycle(r_instr(5'd0, 5'd0, rd), 1'b1, 1'b1, 1'b0, 1'b0, val, 32'h0, 32'h0);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] r, input logic [31:0] exp);
      Instruction = r_instr(r, r, 5'd0);
      #1;
      chk(tag, Read_data_1, exp);
   endtask

   initial begin
      rst_n = 1'b0; Instruction = '0; PC_plus_4 = '0; ALU_Result = '0; mem_data = '0;
      RegWrite = 1'b0; RegDst = 1'b0; MemtoReg = 1'b0; Jal = 1'b0;
      #12 rst_n = 1'b1;

      rd_chk("rst_r0", 5'd0, 32'h0);
      rd_chk("rst_r5", 5'd5, 32'h0);

      // Fill every register, then clear them with a reset pulse between edges.
      for (int i = 1; i < 32; i++) wr_rd(5'(i), 32'hA500_0000 | 32'(i));
      rd_chk("fill_r7", 5'd7, 32'hA500_0007);
      rd_chk("fill_r31", 5'd31, 32'hA500_001F);
      @(negedge clock);
      #1 rst_n = 1'b0;
      for (int i = 0; i < 32; i++) begin
         Instruction = r_instr(5'(i), 5'(31 - i), 5'd0);
         #1;
         chk($sformatf("rstp_rd1_%0d", i), Read_data_1, 32'h0);
         chk($sformatf("rstp_rd2_%0d", i), Read_data_2, 32'h0);
      end
      @(negedge clock);
      rst_n = 1'b1;

      // R-type writeback with read-during-write on rs.
      wr_rd(5'd5, 32'h1111_1111);
      @(negedge clock);
      Instruction = r_instr(5'd5, 5'd0, 5'd5);
      RegWrite = 1'b1; RegDst = 1'b1; MemtoReg = 1'b0; Jal = 1'b0;
      ALU_Result = 32'hDEAD_BEEF;
      #1 chk("rdw_old", Read_data_1, 32'h1111_1111);
      @(posedge clock);
      #1 chk("rdw_new", Read_data_1, 32'hDEAD_BEEF);
      RegWrite = 1'b0; RegDst = 1'b0;

      // Load to rt=8; ALU result must be ignored.
      wb_cycle({6'b100011, 5'd0, 5'd8, 16'h0}, 1'b1, 1'b0, 1'b1, 1'b0,
               32'hBADB_AD00, 32'h0000_1234, 32'h0);
      rd_chk("load_r8", 5'd8, 32'h0000_1234);

      // jal with competing RegDst/MemtoReg: link goes to r31, rd=3 untouched.
      wr_rd(5'd3, 32'h3333_3333);
      wb_cycle(r_instr(5'd0, 5'd0, 5'd3), 1'b1, 1'b1, 1'b1, 1'b1,
               32'h7777_7777, 32'h8888_8888, 32'h0040_0010);
      rd_chk("jal_r31", 5'd31, 32'h0040_0010);
      rd_chk("jal_r3", 5'd3, 32'h3333_3333);
      wb_cycle(r_instr(5'd0, 5'd0, 5'd3), 1'b0, 1'b0, 1'b0, 1'b1,
               32'h7777_7777, 32'h0, 32'h0040_0020);
      rd_chk("jal_nowe", 5'd31, 32'h0040_0020);

      // No strobes: no write.
      wb_cycle(r_instr(5'd0, 5'd0, 5'd3), 1'b0, 1'b1, 1'b0, 1'b0,
               32'h1234_5678, 32'h0, 32'h0);
      rd_chk("nowe_r3", 5'd3, 32'h3333_3333);

      // Register 0 discards writes.
      wb_cycle(r_instr(5'd0, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'h0, 32'h0);
      Instruction = r_instr(5'd0, 5'd0, 5'd0);
      #1;
      chk("r0_rd1", Read_data_1, 32'h0);
      chk("r0_rd2", Read_data_2, 32'h0);

      // Reset asserted mid-cycle with a pending write to r9 loses that write.
      wr_rd(5'd9, 32'h9999_9999);
      rd_chk("pre_r9", 5'd9, 32'h9999_9999);
      @(negedge clock);
      Instruction = r_instr(5'd0, 5'd0, 5'd9);
      RegWrite = 1'b1; RegDst = 1'b1; ALU_Result = 32'h5555_5555;
      #1 rst_n = 1'b0;
      @(posedge clock);
      #1 RegWrite = 1'b0; RegDst = 1'b0;
      @(negedge clock);
      rst_n = 1'b1;
      rd_chk("mid_r9", 5'd9, 32'h0);
      rd_chk("mid_r31", 5'd31, 32'h0);

      // Immediate extension.
      Instruction = i_instr(6'b001000, 16'h8001); #1 chk("ext_addi", Sign_extend, 32'hFFFF_8001);
      Instruction = i_instr(6'b001101, 16'h8001); #1 chk("ext_ori", Sign_extend, 32'h0000_8001);
      Instruction = i_instr(6'b001011, 16'h8001); #1 chk("ext_sltiu", Sign_extend, 32'h0000_8001);
      Instruction = i_instr(6'b001100, 16'h8001); #1 chk("ext_andi", Sign_extend, 32'h0000_8001);
      Instruction = i_instr(6'b001110, 16'h8001); #1 chk("ext_xori", Sign_extend, 32'h0000_8001);
      Instruction = i_instr(6'b001010, 16'h8001); #1 chk("ext_slti", Sign_extend, 32'hFFFF_8001);
      Instruction = i_instr(6'b001111, 16'h8001); #1 chk("ext_lui", Sign_extend, 32'hFFFF_8001);
      Instruction = i_instr(6'b000011, 16'h8001); #1 chk("ext_jal", Sign_extend, 32'hFFFF_8001);
      Instruction = i_instr(6'b001000, 16'h7FFF); #1 chk("ext_pos", Sign_extend, 32'h0000_7FFF);
      rst_n = 1'b0;
      Instruction = i_instr(6'b001000, 16'hC000); #1 chk("ext_inrst", Sign_extend, 32'hFFFF_C000);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
